// File: rtl/dict_probe_ctrl.sv
// dict_probe_ctrl: owns every access to the LZW dictionary RAM.
// Takes one lookup-or-insert request per string and runs a linear-probe
// search over BASE_ADDR..2^ADDR_WIDTH-1 with wrap-around. It answers with
// hit / inserted / fail plus the final address, and flags inserts that
// landed off their home slot so the conflict table can record them.
// Optional build macro: PROBE_STATS_EN adds stat_probes / stat_colls.
module dict_probe_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 12,
    parameter int BASE_ADDR   = 256,
    parameter int RAM_LATENCY = 2,
    parameter int MAX_PROBES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_single,
    input  logic [DATA_WIDTH-1:0] req_str,
    input  logic [ADDR_WIDTH-1:0] req_hash,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic                  rsp_inserted,
    output logic                  rsp_fail,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  coll_we,
    output logic [ADDR_WIDTH-1:0] coll_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_rvalid,
    output logic [ADDR_WIDTH-1:0] dict_count,
    output logic                  dict_full
`ifdef PROBE_STATS_EN
    ,
    output logic [31:0]           stat_probes,
    output logic [31:0]           stat_colls
`endif
);

    localparam int PW = $clog2(MAX_PROBES + 1);
    localparam int LW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] TOP        = '1;
    localparam logic [ADDR_WIDTH-1:0] FULL_CNT   = ADDR_WIDTH'((1 << ADDR_WIDTH) - BASE_ADDR);
    localparam logic [PW-1:0]         LAST_PROBE = PW'(MAX_PROBES - 1);
    localparam logic [LW-1:0]         LAT_LOAD   = LW'(RAM_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        CMP   = 3'd3,
        WRITE = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   str_q, str_d;
    logic [ADDR_WIDTH-1:0]   home_q, home_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [PW-1:0]           probes_q, probes_d;
    logic [LW-1:0]           lat_q, lat_d;
    logic                    hit_q, hit_d;
    logic                    ins_q, ins_d;
    logic                    fail_q, fail_d;
    logic [ADDR_WIDTH-1:0]   rsp_addr_q, rsp_addr_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0]   req_home;

    // Hashes landing in the single-byte region are folded up into the multi-char region.
    assign req_home = (req_hash >= BASE) ? req_hash : (req_hash | BASE);

    assign rsp_valid    = (state_q == RESP);
    assign rsp_hit      = hit_q;
    assign rsp_inserted = ins_q;
    assign rsp_fail     = fail_q;
    assign rsp_addr     = rsp_addr_q;
    assign dict_count   = count_q;
    assign dict_full    = (count_q == FULL_CNT);

    // Next-state, RAM strobes and response bookkeeping for the probe sequencer.
    always_comb begin
        state_d    = state_q;
        str_d      = str_q;
        home_d     = home_q;
        addr_d     = addr_q;
        probes_d   = probes_q;
        lat_d      = lat_q;
        hit_d      = hit_q;
        ins_d      = ins_q;
        fail_d     = fail_q;
        rsp_addr_d = rsp_addr_q;
        count_d    = count_q;
        req_ready  = 1'b0;
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        ram_wdata  = str_q;
        coll_we    = 1'b0;
        coll_addr  = addr_q;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    str_d = req_str;
                    if (req_single) begin
                        // Single bytes live at their own code point; no RAM cycle needed.
                        hit_d      = 1'b1;
                        rsp_addr_d = ADDR_WIDTH'(req_str[7:0]);
                        state_d    = RESP;
                    end else begin
                        home_d   = req_home;
                        addr_d   = req_home;
                        probes_d = '0;
                        state_d  = READ;
                    end
                end
            end
            READ: begin
                ram_cs = 1'b1;
                if (RAM_LATENCY == 1) begin
                    state_d = CMP;
                end else begin
                    lat_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q - LW'(1);
                if (lat_d == '0) state_d = CMP;
            end
            CMP: begin
                if (ram_rvalid && (ram_rdata == str_q)) begin
                    hit_d      = 1'b1;
                    rsp_addr_d = addr_q;
                    state_d    = RESP;
                end else if (!ram_rvalid) begin
                    if (dict_full) begin
                        fail_d     = 1'b1;
                        rsp_addr_d = home_q;
                        state_d    = RESP;
                    end else begin
                        state_d = WRITE;
                    end
                end else if (probes_q == LAST_PROBE) begin
                    fail_d     = 1'b1;
                    rsp_addr_d = home_q;
                    state_d    = RESP;
                end else begin
                    // Wrap back to the first multi-char slot, never into the byte region.
                    probes_d = probes_q + PW'(1);
                    addr_d   = (addr_q == TOP) ? BASE : addr_q + ADDR_WIDTH'(1);
                    state_d  = READ;
                end
            end
            WRITE: begin
                ram_cs  = 1'b1;
                ram_we  = 1'b1;
                coll_we = (addr_q != home_q);
                if (count_q != FULL_CNT) count_d = count_q + ADDR_WIDTH'(1);
                ins_d      = 1'b1;
                rsp_addr_d = addr_q;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    hit_d   = 1'b0;
                    ins_d   = 1'b0;
                    fail_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            str_q      <= '0;
            home_q     <= '0;
            addr_q     <= '0;
            probes_q   <= '0;
            lat_q      <= '0;
            hit_q      <= 1'b0;
            ins_q      <= 1'b0;
            fail_q     <= 1'b0;
            rsp_addr_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            str_q      <= str_d;
            home_q     <= home_d;
            addr_q     <= addr_d;
            probes_q   <= probes_d;
            lat_q      <= lat_d;
            hit_q      <= hit_d;
            ins_q      <= ins_d;
            fail_q     <= fail_d;
            rsp_addr_q <= rsp_addr_d;
            count_q    <= count_d;
        end
    end

`ifdef PROBE_STATS_EN
    logic [31:0] stat_probes_q, stat_probes_d;
    logic [31:0] stat_colls_q, stat_colls_d;

    assign stat_probes = stat_probes_q;
    assign stat_colls  = stat_colls_q;

    // Saturating counters of RAM reads issued and of CMP mismatches.
    always_comb begin
        stat_probes_d = stat_probes_q;
        stat_colls_d  = stat_colls_q;
        if (state_q == READ && stat_probes_q != '1) stat_probes_d = stat_probes_q + 32'd1;
        if (state_q == CMP && ram_rvalid && (ram_rdata != str_q) && stat_colls_q != '1)
            stat_colls_d = stat_colls_q + 32'd1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_probes_q <= '0;
            stat_colls_q  <= '0;
        end else begin
            stat_probes_q <= stat_probes_d;
            stat_colls_q  <= stat_colls_d;
        end
    end
`endif

endmodule

// File: tb/tb_dict_probe_ctrl.sv
// Bench for dict_probe_ctrl: behavioural RAM with fixed read latency,
// a directed vector table, reset-abort sequence, random traffic against a
// dictionary reference model, and a fill-to-full run.
module tb_dict_probe_ctrl;
    localparam int DW    = 64;
    localparam int AW    = 12;
    localparam int L     = 2;
    localparam int MAXP  = 16;
    localparam int FULLN = 4096 - 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_single = 1'b0, rsp_ready = 1'b0;
    logic [DW-1:0] req_str = '0;
    logic [AW-1:0] req_hash = '0;
    logic          req_ready, rsp_valid, rsp_hit, rsp_inserted, rsp_fail;
    logic [AW-1:0] rsp_addr, coll_addr, ram_addr, dict_count;
    logic          coll_we, ram_cs, ram_we, ram_rvalid, dict_full;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    dict_probe_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(256),
                      .RAM_LATENCY(L), .MAX_PROBES(MAXP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_single(req_single),
        .req_str(req_str), .req_hash(req_hash),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_inserted(rsp_inserted), .rsp_fail(rsp_fail), .rsp_addr(rsp_addr),
        .coll_we(coll_we), .coll_addr(coll_addr),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid),
        .dict_count(dict_count), .dict_full(dict_full)
    );

    // ---------------- RAM model (valid bit + data, L-cycle read) ----------------
    logic          mem_v [0:4095];
    logic [DW-1:0] mem_d [0:4095];
    logic          pv    [0:L-1];
    logic [DW-1:0] pd    [0:L-1];
    logic          tb_clr = 1'b0, tb_wr = 1'b0, tb_wv = 1'b0;
    logic [AW-1:0] tb_waddr = '0;
    logic [DW-1:0] tb_wdata = '0;

    always @(posedge clk) begin
        if (tb_clr) for (int i = 0; i < 4096; i++) mem_v[i] <= 1'b0;
        if (tb_wr) begin
            mem_v[tb_waddr] <= tb_wv;
            mem_d[tb_waddr] <= tb_wdata;
        end
        if (ram_cs && ram_we) begin
            mem_v[ram_addr] <= 1'b1;
            mem_d[ram_addr] <= ram_wdata;
        end
        pv[0] <= mem_v[ram_addr];
        pd[0] <= mem_d[ram_addr];
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign ram_rvalid = pv[L-1];
    assign ram_rdata  = pd[L-1];

    // ---------------- reference dictionary ----------------
    bit            ref_v [0:4095];
    logic [DW-1:0] ref_d [0:4095];
    int            ref_cnt = 0;

    typedef struct {
        bit hit; bit ins; bit fail;
        logic [AW-1:0] addr;
        int lat; int reads; int writes; int colls;
        logic [AW-1:0] caddr;
    } res_t;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mem_put(input logic [AW-1:0] a, input bit v, input logic [DW-1:0] d);
        @(negedge clk);
        tb_wr = 1'b1; tb_waddr = a; tb_wv = v; tb_wdata = d;
        @(negedge clk);
        tb_wr = 1'b0;
        ref_v[a] = v;
        ref_d[a] = d;
    endtask

    task automatic mem_clear();
        @(negedge clk);
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
        for (int i = 0; i < 4096; i++) ref_v[i] = 1'b0;
    endtask

    // Walks the probe sequence over the reference dictionary and predicts the outcome.
    task automatic model(input bit s, input logic [AW-1:0] h, input logic [DW-1:0] st,
                         output res_t r);
        logic [AW-1:0] home, a;
        r = '{default: 0};
        if (s) begin
            r.hit = 1; r.addr = {4'h0, st[7:0]}; r.lat = 1;
            return;
        end
        home = (h < 12'h100) ? h + 12'h100 : h;
        a = home;
        for (int k = 0; k < MAXP; k++) begin
            r.reads = k + 1;
            r.lat   = L + 2 + k * (L + 1);
            if (ref_v[a] && ref_d[a] == st) begin
                r.hit = 1; r.addr = a;
                return;
            end
            if (!ref_v[a]) begin
                if (ref_cnt == FULLN) begin
                    r.fail = 1; r.addr = home;
                    return;
                end
                r.ins = 1; r.addr = a; r.lat++; r.writes = 1;
                ref_v[a] = 1; ref_d[a] = st; ref_cnt++;
                if (a != home) begin r.colls = 1; r.caddr = a; end
                return;
            end
            a = (a == 12'hFFF) ? 12'h100 : a + 12'h001;
        end
        r.fail = 1; r.addr = home;
    endtask

    // Drives one request, observes RAM/conflict activity, holds rsp_ready low for dly cycles.
    task automatic do_req(input bit s, input logic [AW-1:0] h, input logic [DW-1:0] st,
                          input int dly, output res_t o);
        int n;
        bit stable;
        logic [15:0] snap;
        o = '{default: 0};
        @(negedge clk);
        req_valid = 1'b1; req_single = s; req_hash = h; req_str = st;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("req_ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        o.lat = 1;
        while (!rsp_valid && o.lat < 400) begin
            if (ram_cs && !ram_we) o.reads++;
            if (ram_cs && ram_we) o.writes++;
            if (coll_we) begin o.colls++; o.caddr = coll_addr; end
            @(negedge clk);
            o.lat++;
        end
        if (!rsp_valid) begin
            chk("rsp_valid_timeout", 0, 1);
            return;
        end
        o.hit = rsp_hit; o.ins = rsp_inserted; o.fail = rsp_fail; o.addr = rsp_addr;
        snap = {rsp_valid, rsp_hit, rsp_inserted, rsp_fail, rsp_addr};
        stable = 1;
        if (ram_cs) stable = 0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if ({rsp_valid, rsp_hit, rsp_inserted, rsp_fail, rsp_addr} !== snap || ram_cs || coll_we)
                stable = 0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_hold_stable", stable, 1);
        chk("after_handshake", {rsp_valid, req_ready, rsp_hit | rsp_inserted | rsp_fail}, 3'b010);
    endtask

    task automatic run_check(input string tag, input bit s, input logic [AW-1:0] h,
                             input logic [DW-1:0] st, input int dly);
        res_t e, o;
        model(s, h, st, e);
        do_req(s, h, st, dly, o);
        chk({tag, "_flags"}, {o.hit, o.ins, o.fail}, {e.hit, e.ins, e.fail});
        chk({tag, "_addr"}, o.addr, e.addr);
        chk({tag, "_latency"}, o.lat, e.lat);
        chk({tag, "_reads"}, o.reads, e.reads);
        chk({tag, "_writes"}, o.writes, e.writes);
        chk({tag, "_colls"}, o.colls, e.colls);
        chk({tag, "_coll_addr"}, o.caddr, e.caddr);
        chk({tag, "_dict_count"}, dict_count, ref_cnt);
        chk({tag, "_dict_full"}, dict_full, (ref_cnt == FULLN));
    endtask

    typedef struct {
        bit s; logic [AW-1:0] h; logic [DW-1:0] st;
        logic [2:0] flags; logic [AW-1:0] addr;
        int lat; int reads; int colls;
    } vec_t;

    vec_t tbl [11];

    initial begin
        res_t e, o;
        logic busy_seen;

        // directed vectors: flags = {hit, inserted, fail}; L=2 -> hit 4, insert 5, +3 per probe
        tbl[0]  = '{1'b1, 12'h000, 64'h41,                  3'b100, 12'h041, 1,  0,  0};
        tbl[1]  = '{1'b0, 12'h3A7, 64'h4142,                3'b010, 12'h3A7, 5,  1,  0};
        tbl[2]  = '{1'b0, 12'h3A7, 64'h4142,                3'b100, 12'h3A7, 4,  1,  0};
        tbl[3]  = '{1'b0, 12'h0A5, 64'h5555,                3'b010, 12'h1A6, 8,  2,  1};
        tbl[4]  = '{1'b0, 12'hFFF, 64'h7777,                3'b010, 12'h100, 8,  2,  1};
        tbl[5]  = '{1'b0, 12'h0A5, 64'h5555,                3'b100, 12'h1A6, 7,  2,  0};
        tbl[6]  = '{1'b0, 12'h800, 64'hC0DE,                3'b001, 12'h800, 49, 16, 0};
        tbl[7]  = '{1'b0, 12'h900, 64'hC0DE,                3'b010, 12'h90F, 50, 16, 1};
        tbl[8]  = '{1'b1, 12'h000, 64'h1234_5678_9ABC_DEFF, 3'b100, 12'h0FF, 1,  0,  0};
        tbl[9]  = '{1'b0, 12'h100, 64'h7777,                3'b100, 12'h100, 4,  1,  0};
        tbl[10] = '{1'b0, 12'h0FF, 64'h7777,                3'b010, 12'h1FF, 5,  1,  0};

        // ---- reset state ----
        mem_clear();
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {req_ready, rsp_valid, rsp_hit, rsp_inserted, rsp_fail,
                           ram_cs, ram_we, coll_we, dict_full}, 9'b1_0000_0000);
        chk("reset_addr_count", {rsp_addr, dict_count}, 24'h0);
        rst = 1'b0;

        // ---- preload occupied slots with non-matching strings ----
        mem_put(12'h1A5, 1'b1, 64'hDEAD);
        mem_put(12'hFFF, 1'b1, 64'hBEEF);
        for (int i = 0; i < 16; i++) mem_put(12'h800 + 12'(i), 1'b1, 64'hA000 + 64'(i));
        for (int i = 0; i < 15; i++) mem_put(12'h900 + 12'(i), 1'b1, 64'hB000 + 64'(i));

        // ---- directed table ----
        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            model(tbl[i].s, tbl[i].h, tbl[i].st, e);
            do_req(tbl[i].s, tbl[i].h, tbl[i].st, i % 3, o);
            chk({tag, "_flags"}, {o.hit, o.ins, o.fail}, tbl[i].flags);
            chk({tag, "_addr"}, o.addr, tbl[i].addr);
            chk({tag, "_latency"}, o.lat, tbl[i].lat);
            chk({tag, "_reads"}, o.reads, tbl[i].reads);
            chk({tag, "_writes"}, o.writes, tbl[i].flags[1]);
            chk({tag, "_colls"}, o.colls, tbl[i].colls);
            chk({tag, "_coll_addr"}, o.caddr, (tbl[i].colls != 0) ? tbl[i].addr : 12'h000);
            chk({tag, "_dict_count"}, dict_count, ref_cnt);
        end
        chk("table_dict_count", dict_count, 5);

        // ---- reset while waiting on the RAM ----
        @(negedge clk);
        req_valid = 1'b1; req_single = 1'b0; req_hash = 12'h444; req_str = 64'h9999;
        @(negedge clk);
        req_valid = 1'b0;          // READ cycle
        @(negedge clk);            // WAIT cycle
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort_state", {ram_cs, ram_we, rsp_valid, req_ready}, 4'b0001);
        chk("rst_abort_count", dict_count, 0);
        rst = 1'b0;
        ref_cnt = 0;
        busy_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || ram_cs || coll_we) busy_seen = 1'b1;
        end
        chk("rst_abort_quiet", busy_seen, 0);
        chk("rst_abort_no_write", mem_v[12'h444], 0);

        // ---- random traffic against the reference model ----
        for (int n = 0; n < 200; n++) begin
            logic [AW-1:0] h;
            logic [DW-1:0] st;
            bit s;
            int pick;
            pick = $urandom_range(0, 2);
            h  = (pick == 0) ? 12'($urandom_range(12'h0A0, 12'h0A7)) :
                 (pick == 1) ? 12'($urandom_range(12'hFF0, 12'hFFF)) :
                               12'($urandom_range(0, 4095));
            s  = ($urandom_range(0, 9) == 0);
            st = s ? {$urandom, $urandom} : 64'hC000 + 64'($urandom_range(0, 19));
            if (n % 10 == 0)
                mem_put(12'($urandom_range(12'hFF0, 12'hFFF)), 1'b1, 64'hD000 + 64'(n));
            run_check($sformatf("rnd%0d", n), s, h, st, $urandom_range(0, 3));
        end

        // ---- fill to full, then probe the full-dictionary corner ----
        rst = 1'b1;
        mem_clear();
        rst = 1'b0;
        ref_cnt = 0;
        for (int a = 12'h100; a <= 12'hFFF; a++)
            run_check("fill", 1'b0, 12'(a), 64'hF000_0000_0000_0000 | 64'(a), 0);
        chk("full_flag", {dict_full, dict_count}, {1'b1, 12'(FULLN)});
        mem_put(12'h555, 1'b0, 64'h0);
        run_check("full_empty_slot", 1'b0, 12'h555, 64'hE555, 1);
        run_check("full_hit", 1'b0, 12'h556, 64'hF000_0000_0000_0556, 0);
        run_check("full_single", 1'b1, 12'h000, 64'h7A, 0);
        chk("full_no_write", mem_v[12'h555], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dict_probe_ctrl.md
Name: dict_probe_ctrl

Overview:
Sequences all accesses to the LZW dictionary RAM (single_port_sync_ram) for the encoder core. It takes one lookup-or-insert request per string (hash plus string) and runs the linear-probe search over addresses 256..4095 with wrap-around. It returns hit, insert or fail together with the final address, and reports off-home inserts for the conflict table. The core no longer drives the RAM or times RAM latency itself.

Parameters:
DATA_WIDTH, 64, string/RAM data width
ADDR_WIDTH, 12, dictionary address width
BASE_ADDR, 256, first multi-char address; 0..BASE_ADDR-1 reserved for single bytes
RAM_LATENCY, 2, cycles from ram_cs to valid ram_rdata/ram_rvalid (>=1)
MAX_PROBES, 16, collision probes before fail (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_single  in  1  single-byte string; no RAM access
req_str  in  DATA_WIDTH  string to find/insert
req_hash  in  ADDR_WIDTH  LFSR hash (home slot)
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  core accepts response
rsp_hit  out  1  string found
rsp_inserted  out  1  string written this request
rsp_fail  out  1  probe limit hit or dictionary full
rsp_addr  out  ADDR_WIDTH  hit/insert address (home slot on fail)
coll_we  out  1  1-cycle pulse: insert landed off home slot
coll_addr  out  ADDR_WIDTH  address of that insert (conflict table hash_in)
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data
ram_rvalid  in  1  entry valid bit of read slot
dict_count  out  ADDR_WIDTH  multi-char entries inserted since reset
dict_full  out  1  dict_count == 2^ADDR_WIDTH - BASE_ADDR

Behaviour:
- Reset: state IDLE; req_ready=1; rsp_*=0, rsp_addr=0; ram_cs=ram_we=0; coll_we=0; dict_count=0. Reset mid-operation abandons the request the same edge: no response, no write, and ram_cs/ram_we are low the following cycle.
- Request latched (str, hash, single) on req_valid & req_ready. req_ready is low in every other state.
- Home slot: req_hash if req_hash >= BASE_ADDR, else req_hash | BASE_ADDR.
- States: IDLE, READ, WAIT, CMP, WRITE, RESP.
- IDLE: single accepted -> RESP with rsp_hit=1, rsp_addr={0, str[7:0]}, no RAM cycle. rsp_valid is high the cycle after acceptance. Multi-char accepted -> READ with addr=home, probes=0.
- READ: ram_cs=1, ram_we=0 for exactly one cycle -> WAIT. The latency counter loads RAM_LATENCY-1.
- WAIT: count down; at 0 -> CMP. When RAM_LATENCY=1, go straight to CMP.
- CMP samples ram_rvalid/ram_rdata:
  - rvalid & rdata==str -> RESP with hit=1, addr=current.
  - !rvalid & !dict_full -> WRITE.
  - !rvalid & dict_full -> RESP with fail=1.
  - rvalid & mismatch: probes+1. If probes+1==MAX_PROBES -> RESP with fail=1, addr=home. Otherwise addr = (addr==2^ADDR_WIDTH-1) ? BASE_ADDR : addr+1, then -> READ.
  - Probing never touches addresses < BASE_ADDR.
- WRITE: ram_cs=ram_we=1, ram_wdata=str, ram_addr=current for one cycle. dict_count+1. If addr!=home, coll_we=1 and coll_addr=addr in that same cycle. Then -> RESP with inserted=1, addr=current.
- RESP: rsp_valid=1 with flags stable until rsp_valid & rsp_ready, then -> IDLE. Flags clear on leaving RESP, and exactly one of hit/inserted/fail is set. A back-to-back request can be accepted the cycle after the handshake.
- Latency from acceptance edge to first rsp_valid cycle:
  - home hit: RAM_LATENCY+2
  - home insert: RAM_LATENCY+3
  - each collision probe: +RAM_LATENCY+1
- dict_count saturates at full; it is never decremented. RAM valid bits are owned by the RAM.

Optional Feature:
PROBE_STATS_EN: when defined, adds outputs stat_probes[31:0] (every RAM read issued) and stat_colls[31:0] (every CMP mismatch). Both are cleared by rst, saturate at all-ones, and increment in the READ and CMP cycles respectively. When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Single-byte request str=0x41, req_single=1 -> rsp_hit=1, rsp_addr=0x041 next cycle; ram_cs never high.
- hash=0x3A7 on empty RAM, str=0x4142, RAM_LATENCY=2 -> ram_we pulse at 0x3A7, rsp_inserted=1, addr=0x3A7, coll_we=0, dict_count=1. Repeat the same request -> rsp_hit=1, addr=0x3A7, rsp_valid 4 cycles after acceptance.
- hash=0x0A5 -> home 0x1A5. Occupy 0x1A5 with a different string -> insert at 0x1A6, coll_we=1, coll_addr=0x1A6.
- hash=0xFFF, with 0xFFF occupied by a mismatch -> next read at 0x100 (wrap), insert at 0x100.
- 16 consecutive occupied mismatching slots from home 0x800 -> rsp_fail=1, rsp_addr=0x800, no write. rst asserted in WAIT of another request -> no rsp_valid, ram_cs low next cycle, req_ready=1.
